fpu_fpadd_pipe: RTL and testbench
=================================

FPU_FPADD_PIPE -- requirements
Module: fpu_fpadd_pipe

Interface
REQ-001 Parameter EXP_W, default 8: exponent field width.
REQ-002 Parameter FRAC_W, default 23: stored fraction width. Word width W = 1+EXP_W+FRAC_W.
REQ-003 Parameter TAG_W, default 4: sideband tag width, carried through unchanged.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  operand set offered.
REQ-007 in_ready  output  1  operand set accepted this cycle when in_valid && in_ready.
REQ-008 do_sub  input  1  1 = srca - srcb; 0 = srca + srcb.
REQ-009 srca, srcb  input  W  IEEE-style operands: sign, exponent, fraction.
REQ-010 in_tag  input  TAG_W  sideband tag.
REQ-011 out_valid  output  1  result present.
REQ-012 out_ready  input  1  consumer accepts when out_valid && out_ready.
REQ-013 dst  output  W  result.
REQ-014 out_tag  output  TAG_W  tag of the operand set that produced dst.
REQ-015 flags  output  4  {invalid, overflow, underflow, inexact} for dst.

Function
REQ-016 The pipeline SHALL have three register stages: S1 unpack/compare/align, S2 add/leading-zero normalise, S3 round/pack.
REQ-017 Latency SHALL be exactly 3 cycles from the accepting edge to out_valid=1 when out_ready is held 1; throughput SHALL be 1 result per cycle.
REQ-018 Stall is global: advance = !out_valid || out_ready; in_ready SHALL equal advance; no stage register changes when advance=0.
REQ-019 Bubbles SHALL NOT be collapsed; an invalid slot propagates as valid=0.
REQ-020 dst, out_tag and flags SHALL hold stable while out_valid=1 and out_ready=0.
REQ-021 The effective sign of b SHALL be srcb sign XOR do_sub.
REQ-022 Denormal inputs (exp=0) SHALL be treated as signed zero.
REQ-023 Alignment SHALL shift the smaller-magnitude significand right, retaining guard, round and sticky bits; sticky SHALL be the OR of all bits shifted past round; shift amounts >= FRAC_W+3 SHALL yield a zero significand with sticky = (operand nonzero).
REQ-024 Addition SHALL be sign-magnitude on FRAC_W+4 bit significands; a subtraction underflow SHALL never occur (larger magnitude minus smaller).
REQ-025 Normalisation SHALL handle carry-out (shift right 1, exp+1) and any leading-zero count up to FRAC_W+3.
REQ-026 Rounding SHALL be round-to-nearest-even; a mantissa carry from rounding SHALL increment the exponent.
REQ-027 A biased result exponent >= 2^EXP_W-1 SHALL produce signed infinity with overflow=1 and inexact=1.
REQ-028 A biased result exponent <= 0 SHALL flush to signed zero with underflow=1 and inexact=1.
REQ-029 An exact zero sum SHALL be +0, except that (-0)+(-0) in effective terms SHALL be -0.
REQ-030 Any NaN input, or inf + (-inf) in effective terms, SHALL produce canonical quiet NaN: sign 0, exponent all-ones, fraction MSB 1, rest 0. invalid=1 SHALL be set for inf-inf and for signalling NaN inputs.
REQ-031 inf + finite SHALL produce that infinity with flags=0.
REQ-032 inexact SHALL be 1 whenever any of guard, round or sticky is nonzero before rounding.

Reset
REQ-033 When reset=1 at an edge, all stage valid bits SHALL clear: out_valid=0, dst=0, out_tag=0, flags=0. In-flight operations SHALL be discarded, including operations accepted in the reset cycle.
REQ-034 in_ready SHALL be 1 in the first cycle after reset deasserts.

Verification (default parameters, out_ready=1 unless stated)
REQ-035 srca=0x3F800000, srcb=0x3F800000, do_sub=0 -> dst=0x40000000 on the 3rd edge after acceptance, flags=0.
REQ-036 srca=0x3F800000, srcb=0x3F800000, do_sub=1 -> dst=0x00000000, flags=0. srca=0x80000000, srcb=0x80000000, do_sub=0 -> dst=0x80000000.
REQ-037 RNE ties: 0x3F800000+0x33800000 -> 0x3F800000, inexact=1. 0x3F800001+0x33800000 -> 0x3F800002, inexact=1.
REQ-038 0x7F7FFFFF+0x7F7FFFFF -> 0x7F800000, overflow=1, inexact=1. 0x7F800000+0xFF800000 -> 0x7FC00000, invalid=1.
REQ-039 Issue 5 tagged ops back-to-back and hold out_ready=0 for 4 cycles -> in_ready drops, out_valid holds the first result stable, and all 5 results emerge in tag order with none lost or duplicated.
REQ-040 Assert reset for 1 cycle while 3 ops are in flight -> out_valid=0 next cycle, and no stale result appears afterwards.

Source files
------------

// File: rtl/fpu_fpadd_pipe_if.sv
// Operand/result handshake bundle for fpu_fpadd_pipe.
//   master: producer/consumer side (drives operands and out_ready)
//   slave : adder side (drives in_ready and results)
//   in_valid/in_ready : operand handshake; do_sub selects srca - srcb
//   srca/srcb         : {sign, exponent, fraction} words, W = 1+EXP_W+FRAC_W
//   in_tag/out_tag    : sideband tag, returned alongside its result
//   out_valid/out_ready, dst, flags {invalid, overflow, underflow, inexact}
interface fpu_fpadd_pipe_if #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23,
  parameter int TAG_W  = 4
);
  localparam int W = 1 + EXP_W + FRAC_W;

  logic             in_valid;
  logic             in_ready;
  logic             do_sub;
  logic [W-1:0]     srca;
  logic [W-1:0]     srcb;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     dst;
  logic [TAG_W-1:0] out_tag;
  logic [3:0]       flags;

  modport master (
    output in_valid, do_sub, srca, srcb, in_tag, out_ready,
    input  in_ready, out_valid, dst, out_tag, flags
  );

  modport slave (
    input  in_valid, do_sub, srca, srcb, in_tag, out_ready,
    output in_ready, out_valid, dst, out_tag, flags
  );
endinterface

// File: rtl/fpu_fpadd_pipe.sv
// Three-stage pipelined floating-point adder/subtractor, round-to-nearest-even.
//   S1: unpack, special-case detect, magnitude compare/swap, align with G/R/S
//   S2: sign-magnitude add, carry / leading-zero normalise
//   S3: round, overflow/underflow handling, pack (this is the output register)
// Ports: clk, reset (sync, active high), bus (fpu_fpadd_pipe_if.slave).
// Stall is global: every stage advances only when the output slot is free or
// being consumed, so in_ready is the same signal.
module fpu_fpadd_pipe #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23,
  parameter int TAG_W  = 4
) (
  input logic             clk,
  input logic             reset,
  fpu_fpadd_pipe_if.slave bus
);
  localparam int W      = 1 + EXP_W + FRAC_W;
  localparam int SW     = FRAC_W + 4;          // hidden + fraction + G/R/S
  localparam int XW     = EXP_W + 2;           // signed exponent with headroom
  localparam int LZ_W   = $clog2(SW + 1);
  localparam int STAGES = 3;
  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [XW-1:0]    EMAX     = XW'((1 << EXP_W) - 1);
  localparam logic [W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, {(FRAC_W-1){1'b0}}};

  typedef struct packed {
    logic              spec;
    logic [W-1:0]      spec_res;
    logic [3:0]        spec_flags;
    logic              sign;
    logic              zsign;      // sign to use if the sum is exactly zero
    logic              eff_sub;
    logic [EXP_W-1:0]  exp;
    logic [SW-1:0]     siga;       // larger magnitude
    logic [SW-1:0]     sigb;       // smaller magnitude, aligned
    logic [TAG_W-1:0]  tag;
  } s1_t;

  typedef struct packed {
    logic              spec;
    logic [W-1:0]      spec_res;
    logic [3:0]        spec_flags;
    logic              sign;
    logic              zsign;
    logic              zero;
    logic [XW-1:0]     exp;        // two's complement
    logic [SW-1:0]     m;          // normalised: m[SW-1] is the hidden bit
    logic [TAG_W-1:0]  tag;
  } s2_t;

  logic [STAGES:1]  vld_pipe_q;
  logic             advance;
  s1_t              s1_d, s1_q;
  s2_t              s2_d, s2_q;
  logic [W-1:0]     dst_d, dst_q;
  logic [TAG_W-1:0] tag_d, tag_q;
  logic [3:0]       flags_d, flags_q;

  assign advance       = !vld_pipe_q[STAGES] || bus.out_ready;
  assign bus.in_ready  = advance;
  assign bus.out_valid = vld_pipe_q[STAGES];
  assign bus.dst       = dst_q;
  assign bus.out_tag   = tag_q;
  assign bus.flags     = flags_q;

  // ---------------- S1 ----------------
  logic                    sa, sb, za, zb, infa, infb, nana, nanb, snana, snanb, a_big, z_sml;
  logic [EXP_W-1:0]        ea, eb, diff;
  logic [FRAC_W-1:0]       fa, fb;
  logic [W-2:0]            mag_a, mag_b;
  logic [SW-1:0]           sig_a, sig_b, sig_sml, aligned;
  logic [2*SW-2:0]         wide;

  always_comb begin
    s1_d  = '0;
    sa    = bus.srca[W-1];
    sb    = bus.srcb[W-1] ^ bus.do_sub;
    ea    = bus.srca[W-2 -: EXP_W];
    eb    = bus.srcb[W-2 -: EXP_W];
    fa    = bus.srca[FRAC_W-1:0];
    fb    = bus.srcb[FRAC_W-1:0];
    za    = (ea == '0);                // denormals collapse to zero
    zb    = (eb == '0);
    infa  = (ea == EXP_ONES) && (fa == '0);
    infb  = (eb == EXP_ONES) && (fb == '0);
    nana  = (ea == EXP_ONES) && (fa != '0);
    nanb  = (eb == EXP_ONES) && (fb != '0);
    snana = nana && !fa[FRAC_W-1];
    snanb = nanb && !fb[FRAC_W-1];
    mag_a = za ? '0 : bus.srca[W-2:0];
    mag_b = zb ? '0 : bus.srcb[W-2:0];
    a_big = (mag_a >= mag_b);
    sig_a = za ? '0 : {1'b1, fa, 3'b000};
    sig_b = zb ? '0 : {1'b1, fb, 3'b000};
    sig_sml = a_big ? sig_b : sig_a;
    z_sml   = a_big ? zb : za;
    diff    = a_big ? (ea - eb) : (eb - ea);
    // Shift into a double-width window; everything below the R position
    // folds into the sticky bit.
    wide = {sig_sml, {(SW-1){1'b0}}} >> diff;
    if (32'(diff) >= SW - 1) begin
      aligned = {{(SW-1){1'b0}}, ~z_sml};
    end else begin
      aligned    = wide[2*SW-2 -: SW];
      aligned[0] = aligned[0] | (|wide[SW-2:0]);
    end

    s1_d.spec = nana | nanb | infa | infb;
    if (nana || nanb) begin
      s1_d.spec_res   = QNAN;
      s1_d.spec_flags = {snana | snanb, 3'b000};
    end else if (infa && infb && (sa != sb)) begin
      s1_d.spec_res   = QNAN;
      s1_d.spec_flags = 4'b1000;
    end else if (infa) begin
      s1_d.spec_res = {sa, EXP_ONES, {FRAC_W{1'b0}}};
    end else if (infb) begin
      s1_d.spec_res = {sb, EXP_ONES, {FRAC_W{1'b0}}};
    end
    s1_d.sign    = a_big ? sa : sb;
    s1_d.zsign   = sa & sb;            // only (-0)+(-0) keeps a negative zero
    s1_d.eff_sub = sa ^ sb;
    s1_d.exp     = a_big ? ea : eb;
    s1_d.siga    = a_big ? sig_a : sig_b;
    s1_d.sigb    = aligned;
    s1_d.tag     = bus.in_tag;
  end

  // ---------------- S2 ----------------
  logic [SW:0]     sum;
  logic [LZ_W-1:0] lz;
  logic            found;

  always_comb begin
    s2_d            = '0;
    s2_d.spec       = s1_q.spec;
    s2_d.spec_res   = s1_q.spec_res;
    s2_d.spec_flags = s1_q.spec_flags;
    s2_d.sign       = s1_q.sign;
    s2_d.zsign      = s1_q.zsign;
    s2_d.tag        = s1_q.tag;
    // Operands are pre-ordered by magnitude so the difference is never negative.
    sum = s1_q.eff_sub ? ({1'b0, s1_q.siga} - {1'b0, s1_q.sigb})
                       : ({1'b0, s1_q.siga} + {1'b0, s1_q.sigb});
    lz    = '0;
    found = 1'b0;
    for (int i = SW - 1; i >= 0; i--) begin
      if (!found) begin
        if (sum[i]) found = 1'b1;
        else        lz    = lz + LZ_W'(1);
      end
    end
    s2_d.zero = (sum == '0);
    if (sum[SW]) begin
      s2_d.m   = {sum[SW:2], sum[1] | sum[0]};
      s2_d.exp = {2'b00, s1_q.exp} + XW'(1);
    end else begin
      s2_d.m   = sum[SW-1:0] << lz;
      s2_d.exp = {2'b00, s1_q.exp} - XW'(lz);
    end
  end

  // ---------------- S3 ----------------
  logic              rnd_up, inexact;
  logic [FRAC_W+1:0] mant;
  logic [XW-1:0]     e_r;
  logic [FRAC_W-1:0] frac_r;

  always_comb begin
    inexact = |s2_q.m[2:0];
    rnd_up  = s2_q.m[2] & (s2_q.m[1] | s2_q.m[0] | s2_q.m[3]);
    mant    = {1'b0, s2_q.m[SW-1:3]} + {{(FRAC_W+1){1'b0}}, rnd_up};
    e_r     = s2_q.exp + XW'(mant[FRAC_W+1]);
    frac_r  = mant[FRAC_W+1] ? mant[FRAC_W:1] : mant[FRAC_W-1:0];
    tag_d   = s2_q.tag;
    if (s2_q.spec) begin
      dst_d   = s2_q.spec_res;
      flags_d = s2_q.spec_flags;
    end else if (s2_q.zero) begin
      dst_d   = {s2_q.zsign, {(W-1){1'b0}}};
      flags_d = 4'b0000;
    end else if ($signed(e_r) >= $signed(EMAX)) begin
      dst_d   = {s2_q.sign, EXP_ONES, {FRAC_W{1'b0}}};
      flags_d = 4'b0101;
    end else if ($signed(e_r) < $signed(XW'(1))) begin
      dst_d   = {s2_q.sign, {(W-1){1'b0}}};
      flags_d = 4'b0011;
    end else begin
      dst_d   = {s2_q.sign, e_r[EXP_W-1:0], frac_r};
      flags_d = {3'b000, inexact};
    end
  end

  // Reset wins over advance, so an operand accepted in the reset cycle is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe_q <= '0;
      s1_q       <= '0;
      s2_q       <= '0;
      dst_q      <= '0;
      tag_q      <= '0;
      flags_q    <= '0;
    end else if (advance) begin
      vld_pipe_q <= {vld_pipe_q[STAGES-1:1], bus.in_valid};
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      dst_q      <= dst_d;
      tag_q      <= tag_d;
      flags_q    <= flags_d;
    end
  end
endmodule

// File: tb/tb_fpu_fpadd_pipe.sv
// Scoreboard bench for fpu_fpadd_pipe: issue() pushes the hand-computed result
// on acceptance, an independent monitor pops and compares on each handshake.
module tb_fpu_fpadd_pipe;
  localparam int EXP_W = 8, FRAC_W = 23, TAG_W = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fpu_fpadd_pipe_if #(.EXP_W(EXP_W), .FRAC_W(FRAC_W), .TAG_W(TAG_W)) bus ();
  fpu_fpadd_pipe #(.EXP_W(EXP_W), .FRAC_W(FRAC_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  typedef struct { logic [31:0] dst; logic [3:0] tag; logic [3:0] flags; } exp_t;
  typedef struct { logic [31:0] a; logic [31:0] b; logic sub; logic [31:0] r; logic [3:0] f; } vec_t;

  exp_t q[$];
  int   nchk = 0;
  int   nfail = 0;

  // flags = {invalid, overflow, underflow, inexact}
  vec_t vecs[16] = '{
    '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000},  // 1-1 = +0
    '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000},  // -0 + -0
    '{32'h80000000, 32'h00000000, 1'b0, 32'h00000000, 4'b0000},  // -0 + +0
    '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001},  // tie, even stays
    '{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'b0001},  // tie, odd rounds up
    '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101},  // overflow
    '{32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 4'b1000},  // inf - inf
    '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b1000},  // inf - inf via do_sub
    '{32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0000},  // quiet NaN in
    '{32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000},  // signalling NaN in
    '{32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 4'b0000},  // -inf + finite
    '{32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 4'b0000},  // denormal as zero
    '{32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 4'b0011},  // underflow flush
    '{32'h7F7FFFFF, 32'h73000000, 1'b0, 32'h7F800000, 4'b0101},  // overflow from rounding
    '{32'h40400000, 32'h40800000, 1'b1, 32'hBF800000, 4'b0000},  // 3 - 4 = -1
    '{32'h3F800000, 32'h00800000, 1'b0, 32'h3F800000, 4'b0001}   // shift past all, sticky
  };

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    nchk++;
    if (act !== expv) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sub,
                       input logic [3:0] tag, input logic [31:0] r, input logic [3:0] f);
    logic acc;
    exp_t e;
    acc = 1'b0;
    bus.in_valid = 1'b1;
    bus.srca     = a;
    bus.srcb     = b;
    bus.do_sub   = sub;
    bus.in_tag   = tag;
    for (int i = 0; i < 40 && !acc; i++) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
    end
    if (acc) begin
      e.dst = r; e.tag = tag; e.flags = f;
      q.push_back(e);
    end else begin
      nchk++;
      nfail++;
      $display("FAIL issue_timeout: tag %h never accepted", tag);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && q.size() > 0; i++) @(posedge clk);
    #1;
    if (q.size() > 0) begin
      nchk++;
      nfail++;
      $display("FAIL drain_timeout: %0d results still outstanding", q.size());
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && bus.out_valid && bus.out_ready) begin
        nchk++;
        if (q.size() == 0) begin
          nfail++;
          $display("FAIL unexpected_result: got dst %h tag %h flags %b, expected nothing",
                   bus.dst, bus.out_tag, bus.flags);
        end else begin
          e = q.pop_front();
          if (bus.dst !== e.dst || bus.out_tag !== e.tag || bus.flags !== e.flags) begin
            nfail++;
            $display("FAIL result_tag%0h: got dst %h tag %h flags %b, expected dst %h tag %h flags %b",
                     e.tag, bus.dst, bus.out_tag, bus.flags, e.dst, e.tag, e.flags);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin : stim
    int n;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.do_sub    = 1'b0;
    bus.srca      = '0;
    bus.srcb      = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset_dst",       64'(bus.dst),       64'd0);
    chk("reset_tag",       64'(bus.out_tag),   64'd0);
    chk("reset_flags",     64'(bus.flags),     64'd0);
    chk("reset_in_ready",  64'(bus.in_ready),  64'd1);

    // Latency: accept edge counts as 1, result visible after the 3rd edge.
    issue(32'h3F800000, 32'h3F800000, 1'b0, 4'hF, 32'h40000000, 4'b0000);
    n = 1;
    while (!bus.out_valid && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency_edges", 64'(n), 64'd3);
    drain();

    // Directed vectors, back to back
    for (int i = 0; i < 16; i++)
      issue(vecs[i].a, vecs[i].b, vecs[i].sub, 4'(i), vecs[i].r, vecs[i].f);
    drain();

    // Backpressure: five tagged ops against a stalled consumer
    bus.out_ready = 1'b0;
    fork
      begin
        issue(32'h3F800000, 32'h40000000, 1'b0, 4'h1, 32'h40400000, 4'b0000);
        issue(32'h40000000, 32'h40000000, 1'b0, 4'h2, 32'h40800000, 4'b0000);
        issue(32'h40400000, 32'h3F800000, 1'b0, 4'h3, 32'h40800000, 4'b0000);
        issue(32'h40800000, 32'h3F800000, 1'b1, 4'h4, 32'h40400000, 4'b0000);
        issue(32'h3F800000, 32'h40000000, 1'b1, 4'h5, 32'hBF800000, 4'b0000);
      end
      begin
        logic [31:0] d0;
        logic [3:0]  t0, f0;
        int k;
        k = 0;
        while (!bus.out_valid && k < 20) begin
          @(posedge clk);
          #1;
          k++;
        end
        chk("stall_first_valid", 64'(bus.out_valid), 64'd1);
        d0 = bus.dst; t0 = bus.out_tag; f0 = bus.flags;
        chk("stall_first_result", {24'd0, t0, d0}, {24'd0, 4'h1, 32'h40400000});
        repeat (4) begin
          @(negedge clk);
          chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
          chk("stall_hold", {23'd0, bus.out_valid, bus.flags, bus.out_tag, bus.dst},
                            {23'd0, 1'b1, f0, t0, d0});
          @(posedge clk);
          #1;
        end
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // Reset with three ops in flight plus one offered during the reset cycle
    issue(32'h3F800000, 32'h3F800000, 1'b0, 4'hA, 32'h40000000, 4'b0000);
    issue(32'h40000000, 32'h40000000, 1'b0, 4'hB, 32'h40800000, 4'b0000);
    issue(32'h40400000, 32'h3F800000, 1'b0, 4'hC, 32'h40800000, 4'b0000);
    reset        = 1'b1;
    q.delete();
    bus.in_valid = 1'b1;
    bus.srca     = 32'h3F800000;
    bus.srcb     = 32'h3F800000;
    bus.do_sub   = 1'b0;
    bus.in_tag   = 4'hD;
    @(posedge clk);
    #1;
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
    chk("flush_in_ready",  64'(bus.in_ready),  64'd1);
    repeat (8) @(posedge clk);
    #1;

    // Pipeline still usable after the flush
    issue(32'h40000000, 32'h40000000, 1'b0, 4'h7, 32'h40800000, 4'b0000);
    drain();
    repeat (4) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nfail);
    $finish;
  end
endmodule
